rect_plotter: RTL and testbench
===============================

// Module: rect_plotter
// PURPOSE
//  Parametrised rectangle rasteriser feeding the vga_adapter pixel-write port (x, y, colour, plot).
//  Accepts one rectangle command via a start/busy/done handshake.
//  Emits one pixel write per clock, in raster order, in filled or outline mode.
//  Sits between the game-board drawing controller and vga_adapter. Draws grid lines, cells and X/O marks.
// PARAMETERS
//  X_W       9    x coordinate / width bit width
//  Y_W       8    y coordinate / height bit width
//  COLOR_W   3    colour bit width
//  SCREEN_W  160  visible columns (used only when RECT_CLIP_EN is defined)
//  SCREEN_H  120  visible rows (used only when RECT_CLIP_EN is defined)
// PORTS
//  clk        in   1        system clock (same clock as vga_adapter)
//  rst        in   1        asynchronous, active-high reset
//  start      in   1        command strobe; sampled only in IDLE
//  abort      in   1        synchronous cancel of the current rectangle
//  x0         in   X_W      top-left x
//  y0         in   Y_W      top-left y
//  width      in   X_W      width in pixels (0 = empty)
//  height     in   Y_W      height in pixels (0 = empty)
//  color_in   in   COLOR_W  fill / outline colour
//  outline    in   1        1 = border pixels only, 0 = filled
//  busy       out  1        high from the cycle after start until done
//  done       out  1        one-cycle pulse after the last pixel
//  plot       out  1        pixel write enable, one cycle per pixel
//  x          out  X_W      pixel x
//  y          out  Y_W      pixel y
//  color      out  COLOR_W  pixel colour
// BEHAVIOUR
//  Reset: plot=0, busy=0, done=0, x=0, y=0, color=0; FSM goes to IDLE.
//  FSM states: IDLE, PLOT, FIN.
//   IDLE -> PLOT when start=1, abort=0, width!=0 and height!=0.
//     On this transition all command inputs are latched; later input changes are ignored.
//   IDLE -> FIN when start=1, abort=0 and (width==0 or height==0). No pixel is written.
//   PLOT -> FIN after the last pixel.
//   FIN -> IDLE unconditionally; done=1 for exactly this one cycle.
//  Timing: start sampled at edge T.
//   First plot=1 with x=x0, y=y0 in cycle T+1. Last pixel in cycle T+N. done in cycle T+N+1.
//   busy=1 for cycles T+1 .. T+N+1 inclusive.
//  Raster order: x runs x0 .. x0+width-1 inside each row; y increments after the last x of a row.
//  Filled mode: N = width*height.
//  Outline mode:
//   - Rows y0 and y0+height-1 are emitted in full.
//   - Each interior row emits x0, then x0+width-1 in the next cycle (only x0 when width==1).
//   - N = width*height if width<=2 or height<=2; otherwise N = 2*width + 2*(height-2).
//  Arithmetic: end coordinates are computed at X_W+1 / Y_W+1 bits.
//  start while busy is ignored; no queueing.
//  abort=1 in PLOT: plot=0 from the next cycle, return to IDLE, no done pulse, busy low next cycle.
//  start and abort high together in IDLE: abort wins, command dropped.
//  color holds the latched colour during PLOT. x, y, color hold their last values when plot=0.
//  rst asserted mid-rectangle: immediate return to reset values; no done pulse.
// CONFIGURATION
//  RECT_CLIP_EN defined:
//   - Pixels with x>=SCREEN_W or y>=SCREEN_H (after wrap) have plot=0 in their cycle.
//   - The cycle is still consumed, so latency and done timing are unchanged.
//  RECT_CLIP_EN undefined: coordinates wrap modulo 2^X_W / 2^Y_W and every pixel has plot=1.
// TESTING
//  1. Filled: x0=10,y0=20,w=3,h=2. Expect 6 plots (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) in T+1..T+6, done at T+7.
//  2. Outline: x0=0,y0=0,w=4,h=4. Expect 12 plots; row 1 = (0,1),(3,1); done at T+13; no interior pixel (1,1).
//  3. Empty: w=0,h=5. Expect plot never high, busy high and done high at T+1 only.
//  4. Abort: 10x10 fill, abort at the 5th plot cycle. Expect no further plots, done never pulses, busy low next cycle.
//  5. Handshake: start pulsed again while busy with different x0. Expect it ignored and the original pixel sequence unchanged.
//  6. RECT_CLIP_EN: x0=158,y0=0,w=4,h=1. Expect plots only at x=158,159; done still at T+5.
//     Without RECT_CLIP_EN: 4 plots, x=158..161.

Source files
------------

// File: rtl/rect_plotter.sv
// Rectangle rasteriser: one pixel write per clock, raster order, filled or outline.
// Optional RECT_CLIP_EN suppresses plot for pixels outside SCREEN_W x SCREEN_H.
module rect_plotter #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 3
`ifdef RECT_CLIP_EN
  ,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     width,
  input  logic [Y_W-1:0]     height,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               outline,
  output logic               busy,
  output logic               done,
  output logic               plot,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] color
);

  typedef enum logic [1:0] {IDLE, PLOT, FIN} state_t;

  state_t             state_q, state_d;
  logic [X_W-1:0]     x0_q, x0_d, w_q, w_d, col_q, col_d;
  logic [Y_W-1:0]     y0_q, y0_d, h_q, h_d, row_q, row_d;
  logic [COLOR_W-1:0] colr_q, colr_d;
  logic               outl_q, outl_d;
  logic               plot_q, plot_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COLOR_W-1:0] color_q, color_d;

  logic               emit, vis, col_last, row_last, interior;
  logic [X_W-1:0]     px;
  logic [Y_W-1:0]     py;

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    colr_d   = colr_q;
    outl_d   = outl_q;
    col_d    = col_q;
    row_d    = row_q;
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    emit     = 1'b0;
    col_last = (col_q == w_q - X_W'(1));
    row_last = (row_q == h_q - Y_W'(1));
    interior = outl_q && (row_q != '0) && !row_last;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          x0_d   = x0;
          y0_d   = y0;
          w_d    = width;
          h_d    = height;
          colr_d = color_in;
          outl_d = outline;
          col_d  = '0;
          row_d  = '0;
          if (width != '0 && height != '0) begin
            state_d = PLOT;
            emit    = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      PLOT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (col_last && row_last) begin
          state_d = FIN;
        end else begin
          emit = 1'b1;
          if (col_last) begin
            col_d = '0;
            row_d = row_q + Y_W'(1);
          end else if (interior && col_q == '0) begin
            // interior outline rows jump straight to the right edge
            col_d = w_q - X_W'(1);
          end else begin
            col_d = col_q + X_W'(1);
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    px = x0_d + col_d;
    py = y0_d + row_d;
`ifdef RECT_CLIP_EN
    vis = ({1'b0, px} < (X_W+1)'(SCREEN_W)) &&
          ({1'b0, py} < (Y_W+1)'(SCREEN_H));
`else
    vis = 1'b1;
`endif
    if (emit && vis) begin
      plot_d  = 1'b1;
      x_d     = px;
      y_d     = py;
      color_d = colr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      colr_q  <= '0;
      outl_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      colr_q  <= colr_d;
      outl_q  <= outl_d;
      col_q   <= col_d;
      row_q   <= row_d;
      plot_q  <= plot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == FIN);
  assign plot  = plot_q;
  assign x     = x_q;
  assign y     = y_q;
  assign color = color_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Bench for rect_plotter: directed cases plus random rectangles
// checked against a pixel-list model built from the drawing rules.
module tb_rect_plotter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, outline;
  logic [8:0] x0, width;
  logic [7:0] y0, height;
  logic [2:0] color_in;
  logic       busy, done, plot;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] color;

  int checks = 0;
  int errors = 0;
  int last_x, last_y, last_c;

  always #5 clk = ~clk;

  rect_plotter dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .width(width), .height(height),
    .color_in(color_in), .outline(outline),
    .busy(busy), .done(done), .plot(plot),
    .x(x), .y(y), .color(color)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit on_screen(input int px, input int py);
`ifdef RECT_CLIP_EN
    return (px < 160) && (py < 120);
`else
    return 1'b1;
`endif
  endfunction

  // noisy: scramble all command inputs (including start) while busy
  task automatic run_rect(input int ax, input int ay, input int aw,
                          input int ah, input int ac, input int ao,
                          input bit noisy);
    int xs[$];
    int ys[$];
    for (int r = 0; r < ah; r++)
      for (int c = 0; c < aw; c++)
        if (!ao || r == 0 || r == ah - 1 || c == 0 || c == aw - 1) begin
          xs.push_back((ax + c) % 512);
          ys.push_back((ay + r) % 256);
        end
    @(negedge clk);
    x0 = 9'(ax); y0 = 8'(ay); width = 9'(aw); height = 8'(ah);
    color_in = 3'(ac); outline = ao[0]; start = 1'b1; abort = 1'b0;
    for (int k = 0; k < xs.size(); k++) begin
      @(negedge clk);
      start = 1'b0;
      if (noisy) begin
        start = 1'($urandom); x0 = 9'($urandom); y0 = 8'($urandom);
        width = 9'($urandom); height = 8'($urandom);
        color_in = 3'($urandom); outline = 1'($urandom);
      end
      chk("busy_px", busy, 1);
      chk("done_px", done, 0);
      if (on_screen(xs[k], ys[k])) begin
        last_x = xs[k]; last_y = ys[k]; last_c = ac;
        chk("plot", plot, 1);
      end else begin
        chk("plot_clip", plot, 0);
      end
      chk("x", x, last_x);
      chk("y", y, last_y);
      chk("color", color, last_c);
    end
    @(negedge clk);
    start = 1'b0;
    chk("done", done, 1);
    chk("busy_fin", busy, 1);
    chk("plot_fin", plot, 0);
    @(negedge clk);
    chk("done_after", done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; outline = 1'b0;
    x0 = '0; y0 = '0; width = '0; height = '0; color_in = '0;
    last_x = 0; last_y = 0; last_c = 0;
    #12;
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_color", color, 0);
    @(negedge clk);
    rst = 1'b0;

    run_rect(10, 20, 3, 2, 5, 0, 1'b0);
    run_rect(0, 0, 4, 4, 3, 1, 1'b0);
    run_rect(7, 7, 0, 5, 2, 0, 1'b0);
    run_rect(30, 40, 6, 3, 6, 0, 1'b1);
    run_rect(158, 0, 4, 1, 4, 0, 1'b0);
    run_rect(500, 250, 5, 8, 1, 1, 1'b0);
    run_rect(3, 3, 1, 4, 7, 1, 1'b0);

    // abort at 5th plot cycle of a 10x10 fill
    @(negedge clk);
    x0 = 9'd20; y0 = 8'd30; width = 9'd10; height = 8'd10;
    color_in = 3'd2; outline = 1'b0; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_x", x, 24);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_plot", plot, 0);
    chk("abort_busy", busy, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_quiet", plot | done | busy, 0);
    end
    last_x = 24; last_y = 30; last_c = 2;

    // start and abort together in IDLE: dropped
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    @(negedge clk);
    chk("sa_plot", plot, 0);

    // async reset mid-rectangle
    x0 = 9'd50; y0 = 8'd60; width = 9'd8; height = 8'd8;
    color_in = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_plot", plot, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_plot", plot, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_x", x, 0);
    chk("mid_rst_color", color, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    last_x = 0; last_y = 0; last_c = 0;

    for (int i = 0; i < 40; i++)
      run_rect($urandom_range(0, 511), $urandom_range(0, 255),
               $urandom_range(0, 6), $urandom_range(0, 6),
               $urandom_range(0, 7), $urandom_range(0, 1),
               1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
